// File: rtl/mvm_uart_ctrl.sv
// Sequencer between the UART RX deframer, the MVM engine and the UART TX serializer.
// Captures one frame, runs the engine handshake, then streams the result LSB byte first.
module mvm_uart_ctrl #(
  parameter int unsigned R       = 2,
  parameter int unsigned C       = 2,
  parameter int unsigned W_K     = 4,
  parameter int unsigned W_X     = 4,
  parameter int unsigned W_Y     = 16,
  parameter int unsigned TIMEOUT = 256,
  localparam int unsigned W_IN   = R*C*W_K + C*W_X,
  localparam int unsigned NB     = (R*W_Y + 7) / 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_valid,
  input  logic [W_IN-1:0]      rx_data,
  output logic                 mvm_valid,
  input  logic                 mvm_ready,
  output logic [R*C*W_K-1:0]   mvm_k,
  output logic [C*W_X-1:0]     mvm_x,
  input  logic                 mvm_y_valid,
  input  logic [R*W_Y-1:0]     mvm_y,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  output logic [7:0]           tx_data,
  output logic                 busy,
  output logic                 done,
  output logic                 overrun,
  output logic                 timeout,
  input  logic                 err_clr
);

  localparam int unsigned W_YB  = NB * 8;
  localparam int unsigned CNT_W = $clog2(TIMEOUT);
  localparam int unsigned IDX_W = (NB > 1) ? $clog2(NB) : 1;

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StSend} state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [IDX_W-1:0] idx_q;
  logic [W_YB-1:0]  y_q;
  logic [W_YB-1:0]  y_ext;
  logic [W_YB-1:0]  y_shift;

  // Result is zero-padded to whole bytes; the register shifts down one byte per accept.
  always_comb begin
    y_ext   = W_YB'(mvm_y);
    y_shift = y_q >> 8;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      idx_q     <= '0;
      y_q       <= '0;
      mvm_valid <= 1'b0;
      mvm_k     <= '0;
      mvm_x     <= '0;
      tx_valid  <= 1'b0;
      tx_data   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      overrun   <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (err_clr) begin
        overrun <= 1'b0;
        timeout <= 1'b0;
      end
      case (state_q)
        StIdle: begin
          if (rx_valid) begin
            // A frame on the done cycle still counts as arriving while busy.
            if (done) begin
              overrun <= 1'b1;
            end else begin
              mvm_k     <= rx_data[W_IN-1:C*W_X];
              mvm_x     <= rx_data[C*W_X-1:0];
              mvm_valid <= 1'b1;
              busy      <= 1'b1;
              state_q   <= StIssue;
            end
          end
        end
        StIssue: begin
          if (mvm_ready) begin
            mvm_valid <= 1'b0;
            cnt_q     <= '0;
            state_q   <= StWait;
          end
        end
        StWait: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (mvm_y_valid) begin
            y_q      <= y_ext;
            tx_data  <= y_ext[7:0];
            tx_valid <= 1'b1;
            idx_q    <= '0;
            state_q  <= StSend;
          end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            timeout <= 1'b1;
            busy    <= 1'b0;
            state_q <= StIdle;
          end
        end
        StSend: begin
          if (tx_ready) begin
            if (idx_q == IDX_W'(NB - 1)) begin
              tx_valid <= 1'b0;
              done     <= 1'b1;
              busy     <= 1'b0;
              state_q  <= StIdle;
            end else begin
              idx_q   <= idx_q + IDX_W'(1);
              y_q     <= y_shift;
              tx_data <= y_shift[7:0];
            end
          end
        end
        default: state_q <= StIdle;
      endcase
      if (rx_valid && (state_q != StIdle)) begin
        overrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mvm_uart_ctrl.sv
// Self-checking bench for mvm_uart_ctrl: directed engine/TX stimulus with a byte scoreboard.
module tb_mvm_uart_ctrl;

  logic        clk;
  logic        rst;
  logic        rx_valid;
  logic [23:0] rx_data;
  logic        mvm_valid;
  logic        mvm_ready;
  logic [15:0] mvm_k;
  logic [7:0]  mvm_x;
  logic        mvm_y_valid;
  logic [31:0] mvm_y;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  tx_data;
  logic        busy;
  logic        done;
  logic        overrun;
  logic        timeout;
  logic        err_clr;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned done_cnt = 0;
  logic [7:0]  exp_q[$];

  mvm_uart_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .rx_valid    (rx_valid),
    .rx_data     (rx_data),
    .mvm_valid   (mvm_valid),
    .mvm_ready   (mvm_ready),
    .mvm_k       (mvm_k),
    .mvm_x       (mvm_x),
    .mvm_y_valid (mvm_y_valid),
    .mvm_y       (mvm_y),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .tx_data     (tx_data),
    .busy        (busy),
    .done        (done),
    .overrun     (overrun),
    .timeout     (timeout),
    .err_clr     (err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Inputs change 2 time units after a rising edge; outputs are sampled on falling edges.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic send_frame(input logic [23:0] f);
    rx_data  = f;
    rx_valid = 1'b1;
    step(1);
    rx_valid = 1'b0;
  endtask

  task automatic pulse_y(input logic [31:0] y);
    for (int i = 0; i < 4; i++) exp_q.push_back(y[8*i +: 8]);
    mvm_y       = y;
    mvm_y_valid = 1'b1;
    step(1);
    mvm_y_valid = 1'b0;
  endtask

  // Returns on the falling edge where done is high.
  task automatic wait_done(input int max_cycles);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < max_cycles && !seen; i++) begin
      @(negedge clk);
      seen = done;
    end
    check("done_seen", {31'b0, seen}, 32'd1);
  endtask

  // Scoreboard: every accepted TX byte must match the next expected result byte.
  always @(negedge clk) begin
    if (!rst && tx_valid && tx_ready) begin
      if (exp_q.size() == 0) check("tx_extra", 32'(exp_q.size()), 32'd1);
      else check("tx_byte", {24'b0, tx_data}, {24'b0, exp_q.pop_front()});
    end
    if (!rst && done) begin
      done_cnt++;
      check("done_after_last", 32'(exp_q.size()), 32'd0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; rx_valid = 1'b0; rx_data = '0; mvm_ready = 1'b0; mvm_y_valid = 1'b0;
    mvm_y = '0; tx_ready = 1'b0; err_clr = 1'b0;
    step(3);
    rst = 1'b0;
    @(negedge clk);
    check("rst_busy", {31'b0, busy}, 0);
    check("rst_mvm_valid", {31'b0, mvm_valid}, 0);
    check("rst_tx_valid", {31'b0, tx_valid}, 0);
    check("rst_done", {31'b0, done}, 0);
    check("rst_flags", {30'b0, overrun, timeout}, 0);
    check("rst_k_x_data", {mvm_k, mvm_x, tx_data}, 0);

    // Basic transaction
    mvm_ready = 1'b1;
    tx_ready  = 1'b1;
    step(1);
    send_frame(24'h123456);
    @(negedge clk);
    check("cap_k", {16'b0, mvm_k}, 32'h1234);
    check("cap_x", {24'b0, mvm_x}, 32'h56);
    check("issue_busy", {31'b0, busy}, 1);
    check("issue_valid", {31'b0, mvm_valid}, 1);
    step(1);
    @(negedge clk);
    check("wait_valid_low", {31'b0, mvm_valid}, 0);
    check("wait_busy", {31'b0, busy}, 1);
    step(2);
    pulse_y(32'hA1B2C3D4);
    wait_done(20);
    step(1);
    @(negedge clk);
    check("basic_done_once", done_cnt, 1);
    check("basic_flags", {30'b0, overrun, timeout}, 0);
    check("basic_idle", {30'b0, busy, tx_valid}, 0);

    // TX backpressure on byte 1
    send_frame(24'hABCDEF);
    step(2);
    pulse_y(32'h11223344);
    step(1);
    tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid", {31'b0, tx_valid}, 1);
      check("bp_hold", {24'b0, tx_data}, 32'h33);
      step(1);
    end
    check("bp_no_done", done_cnt, 1);
    tx_ready = 1'b1;
    wait_done(20);
    step(1);
    check("bp_done_cnt", done_cnt, 2);

    // Overrun during WAIT
    send_frame(24'h123456);
    step(1);
    send_frame(24'hFFFFFF);
    @(negedge clk);
    check("ovr_set", {31'b0, overrun}, 1);
    check("ovr_k_kept", {16'b0, mvm_k}, 32'h1234);
    check("ovr_x_kept", {24'b0, mvm_x}, 32'h56);
    step(1);
    pulse_y(32'hCAFEF00D);
    wait_done(20);
    step(1);
    @(negedge clk);
    check("ovr_sticky", {31'b0, overrun}, 1);
    step(1);
    err_clr = 1'b1;
    step(1);
    err_clr = 1'b0;
    @(negedge clk);
    check("ovr_clr", {31'b0, overrun}, 0);

    // Engine timeout, exactly TIMEOUT cycles after the handshake edge
    step(1);
    send_frame(24'h0F0F0F);
    step(1);
    step(255);
    @(negedge clk);
    check("to_not_yet", {31'b0, timeout}, 0);
    check("to_busy", {31'b0, busy}, 1);
    step(1);
    @(negedge clk);
    check("to_set", {31'b0, timeout}, 1);
    check("to_idle", {30'b0, busy, tx_valid}, 0);
    step(1);
    err_clr = 1'b1;
    step(1);
    err_clr = 1'b0;
    @(negedge clk);
    check("to_clr", {31'b0, timeout}, 0);

    // Result coinciding with the last timeout cycle wins; frame on done cycle is dropped
    step(1);
    send_frame(24'h123456);
    step(1);
    step(255);
    pulse_y(32'h0BADBEEF);
    wait_done(20);
    rx_data  = 24'h777777;
    rx_valid = 1'b1;
    err_clr  = 1'b1;
    step(1);
    rx_valid = 1'b0;
    err_clr  = 1'b0;
    @(negedge clk);
    check("edge_no_timeout", {31'b0, timeout}, 0);
    check("donecyc_overrun", {31'b0, overrun}, 1);
    check("donecyc_idle", {31'b0, busy}, 0);
    check("donecyc_k_kept", {16'b0, mvm_k}, 32'h1234);
    step(1);
    err_clr = 1'b1;
    step(1);
    err_clr = 1'b0;

    // Engine stall: request held with stable operands, counter idle
    mvm_ready = 1'b0;
    send_frame(24'h5A5A5A);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("stall_valid", {31'b0, mvm_valid}, 1);
      check("stall_kx", {8'b0, mvm_k, mvm_x}, 32'h5A5A5A);
      step(1);
    end
    mvm_ready = 1'b1;
    step(1);
    step(250);
    @(negedge clk);
    check("stall_no_timeout", {31'b0, timeout}, 0);
    step(1);
    pulse_y(32'h55667788);
    wait_done(20);
    step(1);

    // Reset in the middle of SEND
    send_frame(24'h246802);
    step(2);
    pulse_y(32'h99887766);
    step(1);
    tx_ready = 1'b0;
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("mrst_tx", {23'b0, tx_valid, tx_data}, 0);
    check("mrst_state", {28'b0, busy, done, mvm_valid, overrun}, 0);
    check("mrst_kx", {8'b0, mvm_k, mvm_x}, 0);
    tx_ready = 1'b1;
    step(1);
    send_frame(24'h135790);
    step(2);
    pulse_y(32'h44332211);
    @(negedge clk);
    check("mrst_first_byte", {24'b0, tx_data}, 32'h11);
    wait_done(20);
    step(2);
    check("final_q_empty", 32'(exp_q.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
